// File: rtl/uart_tx_drain_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
// Defining UART_TX_PARITY_EN adds an even-parity bit between data and stop.
package uart_tx_pkg;

    localparam int DATA_W = 8;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_CAPT,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/uart_tx_drain_if.sv
// FIFO-side and line-side signals of uart_tx_drain; the transmitter uses
// the slave view, whoever drives the FIFO/enable side uses the master view.
interface uart_tx_drain_if;
    import uart_tx_pkg::*;

    logic              enable;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_underflow;
    logic              fifo_rd_en;
    logic              tx;
    logic              busy;
    logic              frame_done;
    logic              empty_seen;

    modport master (
        output enable, fifo_data, fifo_underflow,
        input  fifo_rd_en, tx, busy, frame_done, empty_seen
    );

    modport slave (
        input  enable, fifo_data, fifo_underflow,
        output fifo_rd_en, tx, busy, frame_done, empty_seen
    );

endinterface

// File: rtl/uart_baud_ctr.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, ticks on the last count,
// restarts from 0 on clear (every FSM state entry).
module uart_baud_ctr #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx_drain.sv
// 8N1 UART transmitter that polls an upstream byte FIFO; a captured 0x00
// means "empty" and triggers a one-bit-period back-off. UART_TX_PARITY_EN adds even parity.
module uart_tx_drain
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_drain_if.slave  bus
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              empty_seen_q, empty_seen_d;
    logic              tick, baud_clear;
    logic              tx_o, rd_en_o, busy_o, done_o;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // Counter restarts on every state change; held at zero while idling.
    assign baud_clear = (state_d != state_q) || (state_q == ST_IDLE);

    uart_baud_ctr #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (baud_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.enable) state_d = ST_REQ;
            ST_REQ:   state_d = ST_CAPT;
            ST_CAPT:  state_d = (bus.fifo_data != '0) ? ST_START : ST_HOLD;
            ST_START: if (tick) state_d = ST_DATA;
`ifdef UART_TX_PARITY_EN
            ST_DATA:   if (tick && bit_idx_q == 3'd7) state_d = ST_PARITY;
            ST_PARITY: if (tick) state_d = ST_STOP;
`else
            ST_DATA:   if (tick && bit_idx_q == 3'd7) state_d = ST_STOP;
`endif
            ST_STOP:  if (tick) state_d = ST_IDLE;
            ST_HOLD:  if (tick) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_o    = 1'b1;
        rd_en_o = 1'b0;
        busy_o  = 1'b1;
        done_o  = 1'b0;
        case (state_q)
            ST_IDLE, ST_HOLD: busy_o  = 1'b0;
            ST_REQ:           rd_en_o = 1'b1;
            ST_START:         tx_o    = 1'b0;
            ST_DATA:          tx_o    = shift_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY:        tx_o    = parity_q;
`endif
            ST_STOP:          done_o  = tick;
            default:          ;
        endcase
    end

    assign bus.tx         = tx_o;
    assign bus.fifo_rd_en = rd_en_o;
    assign bus.busy       = busy_o;
    assign bus.frame_done = done_o;
    assign bus.empty_seen = empty_seen_q;

    // Byte is captured in CAPT, the cycle after the FIFO saw the read strobe.
    always_comb begin
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        empty_seen_d = empty_seen_q | bus.fifo_underflow;
`ifdef UART_TX_PARITY_EN
        parity_d     = parity_q;
`endif
        if (state_q == ST_CAPT) begin
            if (bus.fifo_data != '0) begin
                shift_d   = bus.fifo_data;
                bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                parity_d  = ^bus.fifo_data;
`endif
            end else begin
                empty_seen_d = 1'b1;
            end
        end
        if (state_q == ST_DATA && tick) begin
            shift_d   = {1'b0, shift_q[DATA_W-1:1]};
            bit_idx_d = bit_idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q      <= '0;
            bit_idx_q    <= '0;
            empty_seen_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            empty_seen_q <= empty_seen_d;
`ifdef UART_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

endmodule
